fp_writeback_buffer: RTL and testbench
======================================

// Module: fp_writeback_buffer
// PURPOSE
//  Elastic FIFO between floating point execute stage 5 and the writeback arbiter.
//  The FP pipeline cannot stall, so completed results (fx5_*) are queued here while
//  the arbiter grants the write port to the memory pipeline.
//  Drives an almost-full signal to the thread scheduler so it stops issuing FP
//  instructions before results already in flight could overrun the queue.
// PARAMETERS
//  DEPTH        4  entries; power of two, >= 2
//  ISSUE_SLACK  5  FP instructions that can still be in flight after issue stops (stages 1-5)
// PORTS
//  clk                 in   1    clock, all logic on posedge
//  reset               in   1    synchronous, active-low reset
//  fx5_instruction_valid in 1    push request
//  fx5_result          in   512  vector_t lane results
//  fx5_mask_value      in   16   vector_mask_t
//  fx5_thread_idx      in   2    local_thread_idx_t
//  fx5_subcycle        in   4    subcycle_t
//  fx5_dest_reg        in   5    destination register index
//  fx5_dest_vector     in   1    destination is vector register
//  fx5_has_dest        in   1    instruction writes a register
//  fx5_compare         in   1    result is per-lane compare bits
//  fx5_last_subcycle   in   1    final subcycle of instruction
//  wb_fp_ready         in   1    arbiter grants port this cycle
//  fwb_valid           out  1    head entry valid
//  fwb_result .. fwb_last_subcycle  out  (same widths as fx5_*)  head entry fields
//  fwb_almost_full     out  1    to thread_select; blocks FP issue
//  fwb_count           out  $clog2(DEPTH)+1  occupancy
//  fwb_overflow        out  1    sticky: push dropped while full
// BEHAVIOUR
//  - Reset (reset==0 at posedge): rd/wr pointers=0, count=0, fwb_valid=0,
//    fwb_overflow=0, fwb_almost_full=0. Entry payload not reset. Mid-operation
//    reset discards all entries; the next cycle shows the queue empty.
//  - Push = fx5_instruction_valid. Pop = fwb_valid && wb_fp_ready.
//  - Storage is a DEPTH-entry register array. The pointers are $clog2(DEPTH) bits
//    and wrap modulo DEPTH.
//  - fwb_* outputs show the head entry from registers, with no combinational path
//    from fx5_* (except in bypass, see CONFIGURATION).
//  - Base latency: a push at cycle N is visible on fwb_valid at cycle N+1.
//  - Order is strict FIFO across all threads. Subcycles of one instruction stay
//    contiguous and in order.
//  - count: +1 on push only, -1 on pop only, unchanged on push+pop.
//  - Full (count==DEPTH):
//    - push with pop in the same cycle is accepted, count stays DEPTH.
//    - push without pop is dropped, fwb_overflow is set and holds until reset.
//      This is a scheduler bug; the assertion in the bench must never fire.
//  - Empty: pop is impossible; wb_fp_ready is ignored.
//  - fwb_almost_full: registered, equals (next_count > DEPTH - ISSUE_SLACK) when
//    DEPTH > ISSUE_SLACK, else (next_count != 0).
//    Its 1-cycle lag is covered by ISSUE_SLACK counting stage 1.
//  - Head fields hold stable while fwb_valid && !wb_fp_ready.
//  - No arithmetic on payload. Compare-bit packing stays in the writeback stage.
// CONFIGURATION
//  FP_WB_BYPASS_EN defined:
//    - When count==0, push and wb_fp_ready occur in the same cycle, so fwb_* is
//      driven combinationally from fx5_* with fwb_valid=1.
//    - The entry is consumed with zero latency and not written; count stays 0.
//    - If wb_fp_ready==0 in that case, the entry is enqueued normally.
//  FP_WB_BYPASS_EN undefined:
//    - Always registered, with 1-cycle minimum latency.
//    - fwb_* depend only on registers.
// TESTING
//  1. Reset low 2 cycles -> fwb_valid=0, fwb_count=0, fwb_almost_full=0, fwb_overflow=0.
//  2. wb_fp_ready=1, push result=32'h3f800000 x16 at cycle N -> fwb_valid=1,
//     same payload at N+1 (N with FP_WB_BYPASS_EN), count back to 0.
//  3. wb_fp_ready=0, push 4 entries (dest_reg 1..4) -> count=4, almost_full=1.
//     Then ready=1 -> pops dest_reg 1,2,3,4 in order over 4 cycles.
//  4. Full with 5th push and simultaneous pop -> accepted, count=4, no overflow;
//     the 5th entry emerges after the 4 queued entries.
//  5. Full, push with wb_fp_ready=0 -> fwb_overflow=1 and stays 1; head is unchanged.
//  6. Reset asserted with 3 entries queued -> next cycle count=0, fwb_valid=0;
//     a subsequent push emerges normally.

Source files
------------

// File: rtl/fp_writeback_buffer.sv
// fp_writeback_buffer: elastic FIFO between FP execute stage 5 and the
// writeback arbiter. The FP pipeline never stalls, so its results queue here
// while the arbiter serves the memory pipeline. fwb_almost_full tells the
// thread scheduler to stop FP issue early enough that results already in
// flight always fit.
// Optional feature: define FP_WB_BYPASS_EN to let a result pass straight
// through to the arbiter when the queue is empty and the port is granted.
module fp_writeback_buffer #(
  parameter int DEPTH       = 4,
  parameter int ISSUE_SLACK = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fx5_instruction_valid,
  input  logic [511:0]               fx5_result,
  input  logic [15:0]                fx5_mask_value,
  input  logic [1:0]                 fx5_thread_idx,
  input  logic [3:0]                 fx5_subcycle,
  input  logic [4:0]                 fx5_dest_reg,
  input  logic                       fx5_dest_vector,
  input  logic                       fx5_has_dest,
  input  logic                       fx5_compare,
  input  logic                       fx5_last_subcycle,
  input  logic                       wb_fp_ready,
  output logic                       fwb_valid,
  output logic [511:0]               fwb_result,
  output logic [15:0]                fwb_mask_value,
  output logic [1:0]                 fwb_thread_idx,
  output logic [3:0]                 fwb_subcycle,
  output logic [4:0]                 fwb_dest_reg,
  output logic                       fwb_dest_vector,
  output logic                       fwb_has_dest,
  output logic                       fwb_compare,
  output logic                       fwb_last_subcycle,
  output logic                       fwb_almost_full,
  output logic [$clog2(DEPTH):0]     fwb_count,
  output logic                       fwb_overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [511:0] result;
    logic [15:0]  mask_value;
    logic [1:0]   thread_idx;
    logic [3:0]   subcycle;
    logic [4:0]   dest_reg;
    logic         dest_vector;
    logic         has_dest;
    logic         compare;
    logic         last_subcycle;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          in_entry;
  entry_t          out_entry;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count_r;
  logic [CW-1:0]   next_count;
  logic            full;
  logic            pop;
  logic            push_accept;
  logic            drop;
  logic            af_next;

  assign in_entry = '{
    result:        fx5_result,
    mask_value:    fx5_mask_value,
    thread_idx:    fx5_thread_idx,
    subcycle:      fx5_subcycle,
    dest_reg:      fx5_dest_reg,
    dest_vector:   fx5_dest_vector,
    has_dest:      fx5_has_dest,
    compare:       fx5_compare,
    last_subcycle: fx5_last_subcycle
  };

  assign full = (count_r == CW'(DEPTH));
  // Only a stored entry can be popped; ready is ignored while empty.
  assign pop  = (count_r != '0) && wb_fp_ready;

`ifdef FP_WB_BYPASS_EN
  logic bypass_take;
  // Empty queue plus a grant in the push cycle: hand the result over directly.
  assign bypass_take = (count_r == '0) && fx5_instruction_valid && wb_fp_ready;
  assign push_accept = fx5_instruction_valid && !bypass_take && (!full || pop);
  assign out_entry   = bypass_take ? in_entry : mem[rd_ptr];
  assign fwb_valid   = (count_r != '0) || bypass_take;
`else
  assign push_accept = fx5_instruction_valid && (!full || pop);
  assign out_entry   = mem[rd_ptr];
  assign fwb_valid   = (count_r != '0);
`endif

  // A push that finds the queue full with no pop to make room is lost.
  assign drop = fx5_instruction_valid && full && !pop;

  assign next_count = count_r + CW'(push_accept) - CW'(pop);

  // The threshold form needs DEPTH > ISSUE_SLACK; otherwise any occupancy blocks issue.
  generate
    if (DEPTH > ISSUE_SLACK) begin : g_af_thresh
      assign af_next = (int'(next_count) > (DEPTH - ISSUE_SLACK));
    end else begin : g_af_any
      assign af_next = (next_count != '0);
    end
  endgenerate

  // Control state: pointers, occupancy, almost-full and sticky overflow.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      count_r         <= '0;
      fwb_almost_full <= 1'b0;
      fwb_overflow    <= 1'b0;
    end else begin
      if (push_accept) wr_ptr <= wr_ptr + PW'(1);
      if (pop)         rd_ptr <= rd_ptr + PW'(1);
      count_r         <= next_count;
      fwb_almost_full <= af_next;
      if (drop) fwb_overflow <= 1'b1;
    end
  end

  // Payload storage: written on accepted push only, never reset.
  always_ff @(posedge clk) begin
    if (push_accept) mem[wr_ptr] <= in_entry;
  end

  assign fwb_count         = count_r;
  assign fwb_result        = out_entry.result;
  assign fwb_mask_value    = out_entry.mask_value;
  assign fwb_thread_idx    = out_entry.thread_idx;
  assign fwb_subcycle      = out_entry.subcycle;
  assign fwb_dest_reg      = out_entry.dest_reg;
  assign fwb_dest_vector   = out_entry.dest_vector;
  assign fwb_has_dest      = out_entry.has_dest;
  assign fwb_compare       = out_entry.compare;
  assign fwb_last_subcycle = out_entry.last_subcycle;

endmodule

// File: tb/tb_fp_writeback_buffer.sv
// Bench for fp_writeback_buffer (default build, DEPTH=4, ISSUE_SLACK=5).
// Each table row is one clock cycle: inputs are driven after the falling edge
// and the outputs of that cycle are compared before the next rising edge.
module tb_fp_writeback_buffer;

  localparam int EW = 543;

  logic         clk = 1'b0;
  logic         reset;
  logic         fx5_instruction_valid;
  logic [511:0] fx5_result;
  logic [15:0]  fx5_mask_value;
  logic [1:0]   fx5_thread_idx;
  logic [3:0]   fx5_subcycle;
  logic [4:0]   fx5_dest_reg;
  logic         fx5_dest_vector;
  logic         fx5_has_dest;
  logic         fx5_compare;
  logic         fx5_last_subcycle;
  logic         wb_fp_ready;
  logic         fwb_valid;
  logic [511:0] fwb_result;
  logic [15:0]  fwb_mask_value;
  logic [1:0]   fwb_thread_idx;
  logic [3:0]   fwb_subcycle;
  logic [4:0]   fwb_dest_reg;
  logic         fwb_dest_vector;
  logic         fwb_has_dest;
  logic         fwb_compare;
  logic         fwb_last_subcycle;
  logic         fwb_almost_full;
  logic [2:0]   fwb_count;
  logic         fwb_overflow;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  fp_writeback_buffer #(.DEPTH(4), .ISSUE_SLACK(5)) dut (
    .clk(clk), .reset(reset),
    .fx5_instruction_valid(fx5_instruction_valid), .fx5_result(fx5_result),
    .fx5_mask_value(fx5_mask_value), .fx5_thread_idx(fx5_thread_idx),
    .fx5_subcycle(fx5_subcycle), .fx5_dest_reg(fx5_dest_reg),
    .fx5_dest_vector(fx5_dest_vector), .fx5_has_dest(fx5_has_dest),
    .fx5_compare(fx5_compare), .fx5_last_subcycle(fx5_last_subcycle),
    .wb_fp_ready(wb_fp_ready),
    .fwb_valid(fwb_valid), .fwb_result(fwb_result),
    .fwb_mask_value(fwb_mask_value), .fwb_thread_idx(fwb_thread_idx),
    .fwb_subcycle(fwb_subcycle), .fwb_dest_reg(fwb_dest_reg),
    .fwb_dest_vector(fwb_dest_vector), .fwb_has_dest(fwb_has_dest),
    .fwb_compare(fwb_compare), .fwb_last_subcycle(fwb_last_subcycle),
    .fwb_almost_full(fwb_almost_full), .fwb_count(fwb_count),
    .fwb_overflow(fwb_overflow)
  );

  // Every field of an entry is derived from an 8-bit tag; tag 0 gives 32'h3f800000 lanes.
  function automatic logic [EW-1:0] pack_tag(input logic [7:0] t);
    logic [31:0] lane;
    lane = {24'h3f8000, t};
    return {{16{lane}}, {t, ~t}, t[1:0], t[3:0], t[4:0], t[0], t[1], t[2], t[3]};
  endfunction

  function automatic logic [EW-1:0] head_now();
    return {fwb_result, fwb_mask_value, fwb_thread_idx, fwb_subcycle, fwb_dest_reg,
            fwb_dest_vector, fwb_has_dest, fwb_compare, fwb_last_subcycle};
  endfunction

  task automatic drive(input bit rst_n, input bit push, input bit rdy, input logic [7:0] t);
    logic [EW-1:0] e;
    e = pack_tag(t);
    reset = rst_n;
    fx5_instruction_valid = push;
    wb_fp_ready = rdy;
    {fx5_result, fx5_mask_value, fx5_thread_idx, fx5_subcycle, fx5_dest_reg,
     fx5_dest_vector, fx5_has_dest, fx5_compare, fx5_last_subcycle} = e;
  endtask

  task automatic check(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    else
      passed++;
  endtask

  task automatic check_head(input string name, input int row, input logic [7:0] t);
    logic [EW-1:0] exp;
    exp = pack_tag(t);
    total++;
    if (head_now() !== exp)
      $display("FAIL %s row %0d: got dest_reg=%0d lane0=%h expected dest_reg=%0d lane0=%h",
               name, row, fwb_dest_reg, fwb_result[31:0], exp[10:6], exp[EW-481 +: 32]);
    else
      passed++;
  endtask

  typedef struct {
    bit          rst_n;
    bit          push;
    bit          rdy;
    logic [7:0]  tag;
    bit          chk;
    bit          ev;
    logic [7:0]  eh;
    int          ec;
    bit          eaf;
    bit          eov;
  } vec_t;

  vec_t tv[$];

  function automatic void add(input bit rst_n, input bit push, input bit rdy, input int t,
                              input bit chk, input bit ev, input int eh, input int ec,
                              input bit eaf, input bit eov);
    vec_t v;
    v.rst_n = rst_n; v.push = push; v.rdy = rdy; v.tag = 8'(t);
    v.chk = chk; v.ev = ev; v.eh = 8'(eh); v.ec = ec; v.eaf = eaf; v.eov = eov;
    tv.push_back(v);
  endfunction

  initial begin
    //   rst push rdy tag  chk ev head cnt af ovf
    // reset for two cycles
    add(0, 0, 0, 0,    0, 0, 0,  0, 0, 0);
    add(0, 0, 0, 0,    1, 0, 0,  0, 0, 0);
    // single result with ready high: visible next cycle, then drained
    add(1, 1, 1, 0,    1, 0, 0,  0, 0, 0);
    add(1, 0, 1, 0,    1, 1, 0,  1, 1, 0);
    add(1, 0, 0, 0,    1, 0, 0,  0, 0, 0);
    // fill four entries with the arbiter busy
    add(1, 1, 0, 1,    1, 0, 0,  0, 0, 0);
    add(1, 1, 0, 2,    1, 1, 1,  1, 1, 0);
    add(1, 1, 0, 3,    1, 1, 1,  2, 1, 0);
    add(1, 1, 0, 4,    1, 1, 1,  3, 1, 0);
    add(1, 0, 0, 0,    1, 1, 1,  4, 1, 0);
    // full: push with pop is accepted, then drain in order 2,3,4,5
    add(1, 1, 1, 5,    1, 1, 1,  4, 1, 0);
    add(1, 0, 1, 0,    1, 1, 2,  4, 1, 0);
    add(1, 0, 1, 0,    1, 1, 3,  3, 1, 0);
    add(1, 0, 1, 0,    1, 1, 4,  2, 1, 0);
    add(1, 0, 1, 0,    1, 1, 5,  1, 1, 0);
    add(1, 0, 0, 0,    1, 0, 0,  0, 0, 0);
    // fill again, then push while full and stalled: dropped, overflow sticks
    add(1, 1, 0, 6,    1, 0, 0,  0, 0, 0);
    add(1, 1, 0, 7,    1, 1, 6,  1, 1, 0);
    add(1, 1, 0, 8,    1, 1, 6,  2, 1, 0);
    add(1, 1, 0, 9,    1, 1, 6,  3, 1, 0);
    add(1, 1, 0, 10,   1, 1, 6,  4, 1, 0);
    add(1, 0, 0, 0,    1, 1, 6,  4, 1, 1);
    add(1, 0, 0, 0,    1, 1, 6,  4, 1, 1);
    // pop one, reset with three queued, then a fresh push
    add(1, 0, 1, 0,    1, 1, 6,  4, 1, 1);
    add(0, 0, 0, 0,    1, 1, 7,  3, 1, 1);
    add(1, 1, 0, 11,   1, 0, 0,  0, 0, 0);
    add(1, 0, 1, 0,    1, 1, 11, 1, 1, 0);
    add(1, 0, 0, 0,    1, 0, 0,  0, 0, 0);

    drive(0, 0, 0, 0);
    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      drive(tv[i].rst_n, tv[i].push, tv[i].rdy, tv[i].tag);
      #1;
      if (tv[i].chk) begin
        check("valid", i, 32'(fwb_valid), 32'(tv[i].ev));
        check("count", i, 32'(fwb_count), 32'(tv[i].ec));
        check("almost_full", i, 32'(fwb_almost_full), 32'(tv[i].eaf));
        check("overflow", i, 32'(fwb_overflow), 32'(tv[i].eov));
        if (tv[i].ev) check_head("head", i, tv[i].eh);
      end
    end

    // Head must hold every field stable through a multi-cycle stall.
    @(negedge clk); drive(1, 1, 0, 20); #1;
    check("stall_empty", 100, 32'(fwb_valid), 32'd0);
    @(negedge clk); drive(1, 1, 0, 21); #1;
    check_head("stall_head", 101, 8'd20);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); drive(1, 0, 0, 0); #1;
      check_head("stall_hold", 102 + k, 8'd20);
      check("stall_count", 102 + k, 32'(fwb_count), 32'd2);
    end
    @(negedge clk); drive(1, 0, 1, 0); #1;
    check_head("stall_release", 105, 8'd20);
    @(negedge clk); drive(1, 0, 0, 0); #1;
    check_head("second_head", 106, 8'd21);
    check("second_count", 106, 32'(fwb_count), 32'd1);
    @(negedge clk); drive(1, 0, 1, 0); #1;
    check_head("second_pop", 107, 8'd21);
    @(negedge clk); drive(1, 0, 0, 0); #1;
    check("drained_valid", 108, 32'(fwb_valid), 32'd0);
    check("drained_count", 108, 32'(fwb_count), 32'd0);
    check("drained_af", 108, 32'(fwb_almost_full), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
